pe_array_ctrl: RTL and testbench
================================

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 Parameter CURR_ROWS, default 8: cycles needed to load one current block into the PE array.
REQ-002 Parameter SR_V, default 16: vertical candidates per search column (2..256).
REQ-003 Parameter SR_H, default 16: search columns (1..256).
REQ-004 Parameter PIPE_LAT, default 3: cycles from abs_Control=2'b01 to SAD availability (1..8).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  request one full-search run; sampled only in IDLE.
REQ-009 abort  input  1  terminate any run; returns to IDLE.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse at run completion.
REQ-012 in_curr_enable  output  1  PE current-pixel load enable.
REQ-013 CB_select  output  1  current-block bank select.
REQ-014 abs_Control  output  2  00 = idle/zero, 01 = compute SAD term.
REQ-015 ref_input_Control  output  2  00 = load column, 01 = shift down (from up neighbour), 10 = shift up (from down neighbour), 11 = hold.
REQ-016 change_ref  output  1  column-change strobe to the PE array.
REQ-017 sad_valid  output  1  SAD of tagged candidate available this cycle.
REQ-018 cand_x  output  8  column index of the candidate tagged by sad_valid.
REQ-019 cand_y  output  8  row index of the candidate tagged by sad_valid.

Function
REQ-020 FSM states: IDLE, LOAD, SEARCH, DRAIN, DONE; all outputs registered.
REQ-021 IDLE: start=1 and abort=0 -> LOAD; otherwise stay; in_curr_enable=0, abs_Control=00, ref_input_Control=11, change_ref=0.
REQ-022 LOAD: exactly CURR_ROWS cycles; in_curr_enable=1, ref_input_Control=00, abs_Control=00; then -> SEARCH with col=0, row=0.
REQ-023 SEARCH: one candidate per cycle; abs_Control=01; in_curr_enable=0; row counts 0..SR_V-1, then col increments and row returns to 0.
REQ-024 SEARCH snake scan: even col -> cand row = row, ref_input_Control=01; odd col -> cand row = SR_V-1-row, ref_input_Control=10.
REQ-025 On row=SR_V-1 with col<SR_H-1: change_ref=1 and ref_input_Control=00 for that cycle; the candidate is still computed.
REQ-026 On row=SR_V-1 with col=SR_H-1: change_ref=0; next state DRAIN; SEARCH lasts exactly SR_H*SR_V cycles.
REQ-027 DRAIN: exactly PIPE_LAT cycles; abs_Control=00, ref_input_Control=11; then -> DONE.
REQ-028 DONE: one cycle; done=1; CB_select toggles on exit; next state IDLE.
REQ-029 Tag pipeline: the {abs_Control==01, col, cand row} tuple is delayed PIPE_LAT cycles to drive {sad_valid, cand_x, cand_y}; cand_x/cand_y hold their last value when sad_valid=0.
REQ-030 Each run produces exactly SR_H*SR_V sad_valid pulses; the last pulse lands in the final DRAIN cycle.
REQ-031 start while busy is ignored; start held high through DONE starts a new run from IDLE one cycle later.
REQ-032 abort=1 in any state -> IDLE next cycle: tag pipeline flushed (sad_valid=0), no done, CB_select unchanged.
REQ-033 abort and start both high in IDLE: abort wins; stay in IDLE.
REQ-034 Counters wrap only via FSM transitions; SR_H=1 gives no change_ref pulses.

Reset
REQ-035 rst_n=0 forces state IDLE asynchronously and sets busy=0, done=0, in_curr_enable=0, CB_select=0, abs_Control=00, ref_input_Control=11, change_ref=0, sad_valid=0, cand_x=0, cand_y=0, all counters and tag pipeline cleared.
REQ-036 Reset mid-run discards the run; after release the block waits in IDLE for start.

Verification
REQ-037 CURR_ROWS=8, SR_V=4, SR_H=3, PIPE_LAT=3; start sampled at edge 0 -> LOAD cycles 1-8, SEARCH 9-20, DRAIN 21-23, done=1 at cycle 24, busy low at 25.
REQ-038 Same run -> 12 sad_valid pulses, cycles 12-23; (cand_x,cand_y) order (0,0),(0,1),(0,2),(0,3),(1,3),(1,2),(1,1),(1,0),(2,0)...(2,3).
REQ-039 Same run -> change_ref high only at cycles 12 and 16 with ref_input_Control=00; ref_input_Control=10 at cycles 13-15.
REQ-040 Two back-to-back runs -> CB_select 0 during first run, 1 during second, 0 after second done.
REQ-041 abort at cycle 14 -> IDLE at 15, sad_valid=0 from 15, no done, CB_select unchanged; start at 20 runs normally.
REQ-042 rst_n low at cycle 10 -> outputs at reset values immediately (asynchronously); start ignored while rst_n=0.

Source files
------------

// File: rtl/pe_array_ctrl.sv
// PE array controller: loads the current block, snake-scans the search
// window one candidate per cycle and tags each SAD result as it emerges.
module pe_array_ctrl #(
    parameter int CURR_ROWS = 8,
    parameter int SR_V      = 16,
    parameter int SR_H      = 16,
    parameter int PIPE_LAT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       in_curr_enable,
    output logic       CB_select,
    output logic [1:0] abs_Control,
    output logic [1:0] ref_input_Control,
    output logic       change_ref,
    output logic       sad_valid,
    output logic [7:0] cand_x,
    output logic [7:0] cand_y
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEARCH,
        DRAIN,
        DONE
    } state_t;

    localparam logic [15:0] LOAD_LAST  = 16'(CURR_ROWS - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(PIPE_LAT - 1);
    localparam logic [7:0]  ROW_LAST   = 8'(SR_V - 1);
    localparam logic [7:0]  COL_LAST   = 8'(SR_H - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [7:0]  row, row_nxt;
    logic [7:0]  col, col_nxt;

    logic        busy_nxt;
    logic        done_nxt;
    logic        ice_nxt;
    logic [1:0]  abs_nxt;
    logic [1:0]  refc_nxt;
    logic        chg_nxt;
    logic [7:0]  cy_nxt;

    logic [PIPE_LAT-1:0]      pv;
    logic [PIPE_LAT-1:0][7:0] px;
    logic [PIPE_LAT-1:0][7:0] py;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            row               <= '0;
            col               <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            in_curr_enable    <= 1'b0;
            abs_Control       <= 2'b00;
            ref_input_Control <= 2'b11;
            change_ref        <= 1'b0;
            CB_select         <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            row               <= row_nxt;
            col               <= col_nxt;
            busy              <= busy_nxt;
            done              <= done_nxt;
            in_curr_enable    <= ice_nxt;
            abs_Control       <= abs_nxt;
            ref_input_Control <= refc_nxt;
            change_ref        <= chg_nxt;
            if (state == DONE && !abort)
                CB_select <= ~CB_select;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        row_nxt   = row;
        col_nxt   = col;
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            row_nxt   = '0;
            col_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = LOAD;
                        cnt_nxt   = '0;
                    end
                end
                LOAD: begin
                    if (cnt == LOAD_LAST) begin
                        state_nxt = SEARCH;
                        cnt_nxt   = '0;
                        row_nxt   = '0;
                        col_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
                SEARCH: begin
                    if (row != ROW_LAST) begin
                        row_nxt = row + 8'd1;
                    end else if (col != COL_LAST) begin
                        row_nxt = '0;
                        col_nxt = col + 8'd1;
                    end else begin
                        state_nxt = DRAIN;
                        cnt_nxt   = '0;
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST)
                        state_nxt = DONE;
                    else
                        cnt_nxt = cnt + 16'd1;
                end
                DONE: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so they register with it.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
        ice_nxt  = (state_nxt == LOAD);
        abs_nxt  = 2'b00;
        refc_nxt = 2'b11;
        chg_nxt  = 1'b0;
        cy_nxt   = col_nxt[0] ? (ROW_LAST - row_nxt) : row_nxt;
        unique case (state_nxt)
            LOAD: refc_nxt = 2'b00;
            SEARCH: begin
                abs_nxt = 2'b01;
                if (row_nxt == ROW_LAST && col_nxt != COL_LAST) begin
                    chg_nxt  = 1'b1;
                    refc_nxt = 2'b00;
                end else begin
                    refc_nxt = col_nxt[0] ? 2'b10 : 2'b01;
                end
            end
            default: ;
        endcase
    end

    // Stage 0 mirrors the registered controls; the output stage adds the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv        <= '0;
            px        <= '0;
            py        <= '0;
            sad_valid <= 1'b0;
            cand_x    <= '0;
            cand_y    <= '0;
        end else if (abort) begin
            pv        <= '0;
            px        <= '0;
            py        <= '0;
            sad_valid <= 1'b0;
        end else begin
            pv[0] <= (abs_nxt == 2'b01);
            px[0] <= col_nxt;
            py[0] <= cy_nxt;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pv[i] <= pv[i-1];
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
            sad_valid <= pv[PIPE_LAT-1];
            if (pv[PIPE_LAT-1]) begin
                cand_x <= px[PIPE_LAT-1];
                cand_y <= py[PIPE_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl with a 4x3 window and 3-cycle SAD latency.
module tb_pe_array_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       in_curr_enable;
    logic       CB_select;
    logic [1:0] abs_Control;
    logic [1:0] ref_input_Control;
    logic       change_ref;
    logic       sad_valid;
    logic [7:0] cand_x;
    logic [7:0] cand_y;

    pe_array_ctrl #(
        .CURR_ROWS(8),
        .SR_V(4),
        .SR_H(3),
        .PIPE_LAT(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .busy(busy),
        .done(done),
        .in_curr_enable(in_curr_enable),
        .CB_select(CB_select),
        .abs_Control(abs_Control),
        .ref_input_Control(ref_input_Control),
        .change_ref(change_ref),
        .sad_valid(sad_valid),
        .cand_x(cand_x),
        .cand_y(cand_y)
    );

    typedef struct {
        int c;
        int x;
        int y;
    } tag_t;

    tag_t sad_q[$];
    int   cr_q[$];
    int   done_q[$];
    tag_t mt;
    int   mc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int b;

    // Hand-derived snake order for a 4-row, 3-column window.
    int xs[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    int ys[12] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input int base, input int nsad, input int ncr, input bit dn);
        for (int i = 0; i < nsad; i++)
            sad_q.push_back('{base + 12 + i, xs[i], ys[i]});
        if (ncr > 0) cr_q.push_back(base + 12);
        if (ncr > 1) cr_q.push_back(base + 16);
        if (dn) done_q.push_back(base + 24);
    endtask

    task automatic wait_rel(input int base, input int r);
        while (cyc < base + r) @(negedge clk);
    endtask

    // Monitor: pops an expectation for every pulse the DUT presents.
    always @(negedge clk) begin
        if (sad_valid) begin
            checks++;
            if (sad_q.size() == 0) begin
                errors++;
                $display("FAIL sad_extra: got pulse x=%0d y=%0d at cyc %0d required none",
                         cand_x, cand_y, cyc);
            end else begin
                mt = sad_q.pop_front();
                if (mt.c != cyc || mt.x != int'(cand_x) || mt.y != int'(cand_y)) begin
                    errors++;
                    $display("FAIL sad: got cyc=%0d x=%0d y=%0d required cyc=%0d x=%0d y=%0d",
                             cyc, cand_x, cand_y, mt.c, mt.x, mt.y);
                end
            end
        end
        if (change_ref) begin
            checks++;
            if (cr_q.size() == 0) begin
                errors++;
                $display("FAIL change_ref_extra: got pulse at cyc %0d required none", cyc);
            end else begin
                mc = cr_q.pop_front();
                if (mc != cyc || ref_input_Control != 2'b00) begin
                    errors++;
                    $display("FAIL change_ref: got cyc=%0d ctl=%0d required cyc=%0d ctl=0",
                             cyc, ref_input_Control, mc);
                end
            end
        end
        if (done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_extra: got pulse at cyc %0d required none", cyc);
            end else begin
                mc = done_q.pop_front();
                if (mc != cyc) begin
                    errors++;
                    $display("FAIL done: got cyc=%0d required cyc=%0d", cyc, mc);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", int'({busy, done, in_curr_enable, CB_select, abs_Control,
                             ref_input_Control, change_ref, sad_valid}), 'b0000_00_11_0_0);
        chk("rst_cand", int'({cand_x, cand_y}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single run, with a start pulse mid-run that must be ignored.
        start = 1'b1;
        b = cyc;
        push(b, 12, 2, 1'b1);
        wait_rel(b, 1);
        start = 1'b0;
        chk("load_first_ice", int'({busy, in_curr_enable}), 3);
        wait_rel(b, 5);
        start = 1'b1;
        wait_rel(b, 6);
        start = 1'b0;
        wait_rel(b, 8);
        chk("load_last_ice", int'(in_curr_enable), 1);
        wait_rel(b, 9);
        chk("search0", int'({in_curr_enable, abs_Control, ref_input_Control}), 'b0_01_01);
        wait_rel(b, 13);
        chk("odd_col_ref", int'(ref_input_Control), 2);
        wait_rel(b, 17);
        chk("even_col_ref", int'(ref_input_Control), 1);
        wait_rel(b, 21);
        chk("drain", int'({busy, abs_Control, ref_input_Control}), 'b1_00_11);
        wait_rel(b, 25);
        chk("idle_after", int'(busy), 0);
        chk("cb_toggled", int'(CB_select), 1);
        chk("cand_hold", int'({cand_x, cand_y}), {8'd2, 8'd3});

        // Abort mid-search, then a fresh run.
        @(negedge clk);
        start = 1'b1;
        b = cyc;
        push(b, 3, 1, 1'b0);
        wait_rel(b, 1);
        start = 1'b0;
        wait_rel(b, 14);
        abort = 1'b1;
        wait_rel(b, 15);
        abort = 1'b0;
        chk("abort_idle", int'({busy, sad_valid}), 0);
        chk("abort_cb", int'(CB_select), 1);
        wait_rel(b, 20);
        start = 1'b1;
        b = cyc;
        push(b, 12, 2, 1'b1);
        wait_rel(b, 1);
        start = 1'b0;
        wait_rel(b, 25);
        chk("rerun_cb", int'(CB_select), 0);

        // Abort has priority over start in IDLE.
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("abort_wins", int'(busy), 0);
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("abort_wins_stay", int'(busy), 0);

        // Back-to-back runs with start held through DONE.
        start = 1'b1;
        b = cyc;
        push(b, 12, 2, 1'b1);
        push(b + 25, 12, 2, 1'b1);
        wait_rel(b, 10);
        chk("b2b_cb_first", int'(CB_select), 0);
        wait_rel(b, 25);
        chk("b2b_gap_idle", int'(busy), 0);
        wait_rel(b, 26);
        start = 1'b0;
        chk("b2b_second_load", int'(in_curr_enable), 1);
        wait_rel(b, 35);
        chk("b2b_cb_second", int'(CB_select), 1);
        wait_rel(b, 51);
        chk("b2b_cb_after", int'({busy, CB_select}), 0);

        // Asynchronous reset mid-search.
        start = 1'b1;
        b = cyc;
        wait_rel(b, 1);
        start = 1'b0;
        wait_rel(b, 10);
        chk("pre_reset_abs", int'(abs_Control), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", int'({busy, in_curr_enable, abs_Control, ref_input_Control}),
            'b0_0_00_11);
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ignores_start", int'(busy), 0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wait_idle", int'({busy, CB_select}), 0);

        repeat (5) @(negedge clk);
        chk("sad_q_empty", sad_q.size(), 0);
        chk("cr_q_empty", cr_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
